// File: rtl/mcdf_pkg.sv
// Shared MCDF definitions: data width, formatter FSM encoding and the
// pkglen_sel to packet-length decode used by several blocks.
package mcdf_pkg;

  localparam int DATA_W  = 32;
  localparam int MAX_LEN = 32;

  typedef enum logic [2:0] {
    IDLE,
    REQ_ID,
    RECV,
    SEND_REQ,
    SEND
  } fmt_state_e;

  // Codes 4..7 are reserved and fall back to the largest packet.
  function automatic logic [5:0] pkglen_decode(input logic [2:0] sel);
    case (sel)
      3'd0:    return 6'd4;
      3'd1:    return 6'd8;
      3'd2:    return 6'd16;
      default: return 6'd32;
    endcase
  endfunction

endpackage

// File: rtl/fmt_buffer.sv
// Packet word buffer for the formatter: one synchronous write port and one
// registered read port; the array itself carries no reset.
module fmt_buffer #(
  parameter int DW    = 32,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read data only moves on a read, so the output word holds between packets.
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) rdata_d = mem_q[raddr_i];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/formatter.sv
// MCDF packet formatter: fetches one packet from the arbiter into a local
// buffer, then requests the output bus and streams it with start/end framing.
module formatter #(
  parameter int DATA_W  = mcdf_pkg::DATA_W,
  parameter int MAX_LEN = mcdf_pkg::MAX_LEN
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              f2a_id_req_o,
  output logic              f2a_ack_o,
  input  logic              a2f_val_i,
  input  logic [1:0]        a2f_id_i,
  input  logic [DATA_W-1:0] a2f_data_i,
  input  logic [2:0]        a2f_pkglen_sel_i,
  output logic              fmt_req_o,
  input  logic              fmt_grant_i,
  output logic [1:0]        fmt_chid_o,
  output logic [5:0]        fmt_length_o,
  output logic [DATA_W-1:0] fmt_data_o,
  output logic              fmt_start_o,
  output logic              fmt_end_o
);
  import mcdf_pkg::*;

  localparam int AW = $clog2(MAX_LEN);

  fmt_state_e    state_q, state_d;
  logic [5:0]    count_q, count_d;
  logic [5:0]    len_q, len_d;
  logic [AW-1:0] rd_idx_q, rd_idx_d;
  logic [1:0]    chid_q, chid_d;
  logic          start_q, start_d;
  logic          end_q, end_d;

  logic          buf_we;
  logic [AW-1:0] buf_waddr;
  logic          buf_re;
  logic [AW-1:0] buf_raddr;

  assign f2a_ack_o = a2f_val_i && (state_q == REQ_ID || state_q == RECV);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    len_d     = len_q;
    rd_idx_d  = rd_idx_q;
    chid_d    = chid_q;
    start_d   = 1'b0;
    end_d     = 1'b0;
    buf_we    = 1'b0;
    buf_waddr = count_q[AW-1:0];
    buf_re    = 1'b0;
    buf_raddr = '0;
    case (state_q)
      IDLE: state_d = REQ_ID;
      REQ_ID: begin
        if (a2f_val_i) begin
          buf_we    = 1'b1;
          buf_waddr = '0;
          chid_d    = a2f_id_i;
          len_d     = pkglen_decode(a2f_pkglen_sel_i);
          count_d   = 6'd1;
          state_d   = RECV;
        end
      end
      RECV: begin
        if (a2f_val_i) begin
          buf_we  = 1'b1;
          count_d = count_q + 6'd1;
          if (count_d == len_q) state_d = SEND_REQ;
        end
      end
      SEND_REQ: begin
        // Prefetch word 0 on the grant edge so it is on the bus the next cycle.
        if (fmt_grant_i) begin
          buf_re    = 1'b1;
          buf_raddr = '0;
          rd_idx_d  = '0;
          start_d   = 1'b1;
          end_d     = (len_q == 6'd1);
          state_d   = SEND;
        end
      end
      SEND: begin
        if ({1'b0, rd_idx_q} == len_q - 6'd1) begin
          rd_idx_d = '0;
          state_d  = REQ_ID;
        end else begin
          rd_idx_d  = rd_idx_q + 1'b1;
          buf_re    = 1'b1;
          buf_raddr = rd_idx_d;
          end_d     = ({1'b0, rd_idx_d} == len_q - 6'd1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      count_q  <= '0;
      len_q    <= '0;
      rd_idx_q <= '0;
      chid_q   <= '0;
      start_q  <= 1'b0;
      end_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      len_q    <= len_d;
      rd_idx_q <= rd_idx_d;
      chid_q   <= chid_d;
      start_q  <= start_d;
      end_q    <= end_d;
    end
  end

  fmt_buffer #(
    .DW    (DATA_W),
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buffer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (buf_we),
    .waddr_i (buf_waddr),
    .wdata_i (a2f_data_i),
    .re_i    (buf_re),
    .raddr_i (buf_raddr),
    .rdata_o (fmt_data_o)
  );

  assign f2a_id_req_o = (state_q == REQ_ID);
  assign fmt_req_o    = (state_q == SEND_REQ);
  assign fmt_chid_o   = chid_q;
  assign fmt_length_o = len_q;
  assign fmt_start_o  = start_q;
  assign fmt_end_o    = end_q;

endmodule
